// File: rtl/i2c_target_pcf8574.sv
// PCF8574-style I2C target: writes land on port_out with an rx_valid strobe,
// reads return the sampled port_in. SCL/SDA are oversampled by clk (>= 10x SCL).
module i2c_target_pcf8574 #(
    parameter logic [6:0] TARGET_ADDR = 7'h27,
    parameter logic [7:0] PORT_RESET  = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] port_in,
    output logic [7:0] port_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t     state;
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic       rw;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    // Synchronizers reset to the idle-bus level so reset release raises no false edges.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    // rx_valid is a one-clk strobe with no back-pressure: rx_data and port_out
    // already hold the new byte in the cycle rx_valid is high and stay until the next byte.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state      <= IDLE;
            sda_oe     <= 1'b0;
            port_out   <= PORT_RESET;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            shift      <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_done  <= 1'b0;
            rw         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (start_det) begin
                state      <= ADDR;
                bit_cnt    <= 3'd0;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
                byte_done  <= 1'b0;
            end else if (stop_det) begin
                state      <= IDLE;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
                byte_done  <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift[6:0] == TARGET_ADDR) begin
                                    addr_match <= 1'b1;
                                    rw         <= sda_s;
                                    byte_done  <= 1'b1;
                                end else begin
                                    state  <= IGNORE;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end else if (scl_fall && byte_done) begin
                            sda_oe    <= 1'b1;
                            byte_done <= 1'b0;
                            state     <= ADDR_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                shift  <= port_in;
                                sda_oe <= ~port_in[7];
                                state  <= RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= {shift[6:0], sda_s};
                                port_out  <= {shift[6:0], sda_s};
                                rx_valid  <= 1'b1;
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            sda_oe    <= 1'b1;
                            byte_done <= 1'b0;
                            state     <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                byte_done <= 1'b1;
                        end else if (scl_fall) begin
                            if (byte_done) begin
                                sda_oe    <= 1'b0;
                                byte_done <= 1'b0;
                                state     <= RD_ACK;
                            end else begin
                                shift  <= {shift[6:0], 1'b0};
                                sda_oe <= ~shift[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        // byte_done here marks "controller acked, reload on next fall".
                        if (scl_rise) begin
                            if (sda_s) begin
                                state  <= IGNORE;
                                sda_oe <= 1'b0;
                            end else begin
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            shift     <= port_in;
                            sda_oe    <= ~port_in[7];
                            state     <= RD_DATA;
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
